// File: rtl/pipe_ctrl_unit.sv
// Pipeline control FSM for the 16-bit RISC core: fetch/execute enables, control-op
// stall sequencing, halt/resume, PC wrap detect and saturating performance counters.
module pipe_ctrl_unit #(
  parameter int PC_W       = 16,
  parameter int IMEM_SIZE  = 32,
  parameter int CTRL_STALL = 3,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        if_opcode,
  input  logic [3:0]        ex_opcode,
  input  logic              rs_less_zero,
  input  logic [PC_W-1:0]   pc_val,
  input  logic              resume,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              pc_sel,
  output logic              pc_wrap,
  output logic              ir_wr,
  output logic              rf_wr,
  output logic              rf_wr_sel,
  output logic              dmem_wr,
  output logic              stall,
  output logic              halted,
  output logic [PERF_W-1:0] cyc_cnt,
  output logic [PERF_W-1:0] stl_cnt
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_BLZ = 4'b1000;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_JAL = 4'b1010;
  localparam logic [3:0] OP_RET = 4'b1011;
  localparam logic [3:0] OP_LI  = 4'b1100;
  localparam logic [3:0] OP_LW  = 4'b1101;
  localparam logic [3:0] OP_SW  = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        capOp_q, capOp_d;
  logic              stall_q, halted_q;
  logic [PERF_W-1:0] cycCnt_q, stlCnt_q;

  logic ifStallOp;
  logic datapathEn;
  logic linkWr;
  logic active;

  assign ifStallOp = (if_opcode[3:2] == 2'b10) || (if_opcode == OP_HLT);
  assign active    = (state_q == ST_RUN) || (state_q == ST_STALL);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capOp_d    = capOp_q;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_sel     = 1'b0;
    ir_wr      = 1'b0;
    linkWr     = 1'b0;
    datapathEn = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_RUN;
      ST_RUN: begin
        datapathEn = 1'b1;
        if (ifStallOp) begin
          capOp_d = if_opcode;
          cnt_d   = 4'(CTRL_STALL - 1);
          state_d = ST_STALL;
        end else begin
          pc_inc = 1'b1;
          ir_wr  = 1'b1;
        end
      end
      ST_STALL: begin
        datapathEn = 1'b1;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        // Target is presented one cycle before the refetch so the new IR sees it.
        if (cnt_q == 4'd1) begin
          pc_load = ((capOp_q == OP_BLZ) && rs_less_zero) || (capOp_q == OP_JMP) ||
                    (capOp_q == OP_JAL) || (capOp_q == OP_RET);
          pc_sel  = (capOp_q == OP_RET);
          linkWr  = (capOp_q == OP_JAL);
        end
        if (cnt_q == 4'd0) begin
          if (capOp_q == OP_HLT) begin
            state_d = ST_HALT;
          end else begin
            ir_wr   = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_HALT: if (resume) state_d = ST_RUN;
      default: state_d = ST_HALT;
    endcase
  end

  assign rf_wr     = (datapathEn && ((ex_opcode[3] == 1'b0) || (ex_opcode == OP_LI) ||
                                     (ex_opcode == OP_LW))) || linkWr;
  assign rf_wr_sel = linkWr;
  assign dmem_wr   = datapathEn && (ex_opcode == OP_SW);
  assign pc_wrap   = (pc_val == PC_W'(IMEM_SIZE));
  assign stall     = stall_q;
  assign halted    = halted_q;
  assign cyc_cnt   = cycCnt_q;
  assign stl_cnt   = stlCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RST;
      cnt_q    <= 4'd0;
      capOp_q  <= 4'd0;
      stall_q  <= 1'b0;
      halted_q <= 1'b0;
      cycCnt_q <= '0;
      stlCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      capOp_q  <= capOp_d;
      stall_q  <= (state_d == ST_STALL);
      halted_q <= (state_d == ST_HALT);
      if (active && (cycCnt_q != PERF_MAX)) cycCnt_q <= cycCnt_q + 1'b1;
      if ((state_q == ST_STALL) && (stlCnt_q != PERF_MAX)) stlCnt_q <= stlCnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one-cycle-per-row vector table plus hand sequences
// for reset abort and counter saturation (a PERF_W=4 instance shares all inputs).
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  if_opcode, ex_opcode;
  logic        rs_less_zero, resume;
  logic [15:0] pc_val;

  logic pc_inc, pc_load, pc_sel, pc_wrap, ir_wr, rf_wr, rf_wr_sel, dmem_wr, stall, halted;
  logic [15:0] cyc_cnt, stl_cnt;

  logic s_pc_inc, s_pc_load, s_pc_sel, s_pc_wrap, s_ir_wr, s_rf_wr, s_rf_wr_sel;
  logic s_dmem_wr, s_stall, s_halted;
  logic [3:0] s_cyc_cnt, s_stl_cnt;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.PC_W(16), .IMEM_SIZE(32), .CTRL_STALL(3), .PERF_W(16)) dut (
    .clk(clk), .rst(rst), .if_opcode(if_opcode), .ex_opcode(ex_opcode),
    .rs_less_zero(rs_less_zero), .pc_val(pc_val), .resume(resume),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_sel(pc_sel), .pc_wrap(pc_wrap),
    .ir_wr(ir_wr), .rf_wr(rf_wr), .rf_wr_sel(rf_wr_sel), .dmem_wr(dmem_wr),
    .stall(stall), .halted(halted), .cyc_cnt(cyc_cnt), .stl_cnt(stl_cnt)
  );

  pipe_ctrl_unit #(.PC_W(16), .IMEM_SIZE(32), .CTRL_STALL(3), .PERF_W(4)) dutSat (
    .clk(clk), .rst(rst), .if_opcode(if_opcode), .ex_opcode(ex_opcode),
    .rs_less_zero(rs_less_zero), .pc_val(pc_val), .resume(resume),
    .pc_inc(s_pc_inc), .pc_load(s_pc_load), .pc_sel(s_pc_sel), .pc_wrap(s_pc_wrap),
    .ir_wr(s_ir_wr), .rf_wr(s_rf_wr), .rf_wr_sel(s_rf_wr_sel), .dmem_wr(s_dmem_wr),
    .stall(s_stall), .halted(s_halted), .cyc_cnt(s_cyc_cnt), .stl_cnt(s_stl_cnt)
  );

  // Control bits packed as {pc_inc,pc_load,pc_sel,ir_wr,rf_wr,rf_wr_sel,dmem_wr,stall,halted,pc_wrap}
  logic [9:0] actCtl;
  assign actCtl = {pc_inc, pc_load, pc_sel, ir_wr, rf_wr, rf_wr_sel, dmem_wr, stall, halted, pc_wrap};

  typedef struct {
    logic [3:0]  ifOp;
    logic [3:0]  exOp;
    logic        rlz;
    logic        res;
    logic [15:0] pcVal;
    logic [9:0]  expCtl;
    logic [15:0] expCyc;
    logic [15:0] expStl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] ifOp, input logic [3:0] exOp, input logic rlz,
                              input logic res, input logic [15:0] pcVal, input logic [9:0] expCtl,
                              input logic [15:0] expCyc, input logic [15:0] expStl);
    vec_t v;
    v.ifOp = ifOp; v.exOp = exOp; v.rlz = rlz; v.res = res; v.pcVal = pcVal;
    v.expCtl = expCtl; v.expCyc = expCyc; v.expStl = expStl;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    if_opcode    = v.ifOp;
    ex_opcode    = v.exOp;
    rs_less_zero = v.rlz;
    resume       = v.res;
    pc_val       = v.pcVal;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Opcodes: BLZ 8, JMP 9, JAL A, RET B, LI C, LW D, SW E, HLT F
    vecs.push_back(mk(4'h0, 4'h3, 0, 0, 16'd0,  10'b0000000000,  0,  0)); // RST cycle
    vecs.push_back(mk(4'h0, 4'hC, 0, 0, 16'd0,  10'b1001100000,  0,  0)); // first RUN
    vecs.push_back(mk(4'h9, 4'hE, 0, 0, 16'd0,  10'b0000001000,  1,  0)); // JMP fetched
    vecs.push_back(mk(4'h0, 4'hD, 0, 0, 16'd0,  10'b0000100100,  2,  0));
    vecs.push_back(mk(4'h0, 4'hE, 0, 0, 16'd0,  10'b0100001100,  3,  1)); // redirect
    vecs.push_back(mk(4'h0, 4'h9, 0, 0, 16'd0,  10'b0001000100,  4,  2)); // refetch
    vecs.push_back(mk(4'h8, 4'h1, 0, 0, 16'd0,  10'b0000100000,  5,  3)); // BLZ fetched
    vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'd0,  10'b0000100100,  6,  3));
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b0000000100,  7,  4)); // not taken
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 16'd0,  10'b0001000100,  8,  5));
    vecs.push_back(mk(4'h8, 4'hF, 0, 0, 16'd0,  10'b0000000000,  9,  6)); // BLZ again
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b0000000100, 10,  6));
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 16'd0,  10'b0100000100, 11,  7)); // taken
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b0001000100, 12,  8));
    vecs.push_back(mk(4'hA, 4'hF, 0, 0, 16'd0,  10'b0000000000, 13,  9)); // JAL fetched
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b0000000100, 14,  9));
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b0100110100, 15, 10)); // link write
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b0001000100, 16, 11));
    vecs.push_back(mk(4'hB, 4'hF, 0, 0, 16'd0,  10'b0000000000, 17, 12)); // RET fetched
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b0000000100, 18, 12));
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b0110000100, 19, 13)); // return target
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b0001000100, 20, 14));
    vecs.push_back(mk(4'hF, 4'hE, 0, 0, 16'd0,  10'b0000001000, 21, 15)); // HLT fetched
    vecs.push_back(mk(4'h0, 4'hE, 0, 0, 16'd0,  10'b0000001100, 22, 15));
    vecs.push_back(mk(4'h0, 4'hE, 0, 0, 16'd0,  10'b0000001100, 23, 16));
    vecs.push_back(mk(4'h0, 4'hE, 0, 0, 16'd0,  10'b0000001100, 24, 17));
    vecs.push_back(mk(4'h0, 4'hE, 0, 0, 16'd0,  10'b0000000010, 25, 18)); // HALT, no SW
    vecs.push_back(mk(4'h0, 4'h3, 0, 1, 16'd0,  10'b0000000010, 25, 18)); // resume
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd0,  10'b1001000000, 25, 18));
    vecs.push_back(mk(4'h0, 4'hF, 0, 1, 16'd0,  10'b1001000000, 26, 18)); // stray resume
    vecs.push_back(mk(4'h0, 4'hF, 0, 0, 16'd32, 10'b1001000001, 27, 18)); // wrap
    vecs.push_back(mk(4'h0, 4'hE, 0, 0, 16'd31, 10'b1001001000, 28, 18));

    rst = 1'b1;
    applyStimulus(mk(4'h0, 4'h0, 0, 0, 16'd0, 10'b0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d ctl", i), 32'(actCtl), 32'(vecs[i].expCtl));
      checkOutput($sformatf("row%0d cyc_cnt", i), 32'(cyc_cnt), 32'(vecs[i].expCyc));
      checkOutput($sformatf("row%0d stl_cnt", i), 32'(stl_cnt), 32'(vecs[i].expStl));
      nextCycle();
    end

    @(negedge clk);
    checkOutput("sat4 cyc_cnt after table", 32'(s_cyc_cnt), 32'd15);
    checkOutput("sat4 stl_cnt after table", 32'(s_stl_cnt), 32'd15);

    // Abort a JMP on its redirect cycle; the pending target must not surface after reset.
    applyStimulus(mk(4'h9, 4'hF, 0, 0, 16'd0, 10'b0, 0, 0));
    nextCycle();
    if_opcode = 4'h0;
    nextCycle();
    @(negedge clk);
    checkOutput("redirect before abort", 32'(pc_load), 32'd1);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort ctl", 32'(actCtl), 32'd0);
    checkOutput("abort cyc_cnt", 32'(cyc_cnt), 32'd0);
    checkOutput("abort stl_cnt", 32'(stl_cnt), 32'd0);
    checkOutput("abort sat4 cyc_cnt", 32'(s_cyc_cnt), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("post-abort RUN ctl", 32'(actCtl), 32'(10'b1001000000));
    checkOutput("post-abort cyc_cnt", 32'(cyc_cnt), 32'd0);

    repeat (19) @(posedge clk);
    @(negedge clk);
    checkOutput("20 RUN cycles cyc_cnt", 32'(cyc_cnt), 32'd19);
    @(posedge clk);
    @(negedge clk);
    checkOutput("20 RUN cycles cyc_cnt final", 32'(cyc_cnt), 32'd20);
    checkOutput("sat4 cyc_cnt held", 32'(s_cyc_cnt), 32'd15);
    checkOutput("sat4 stl_cnt idle", 32'(s_stl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
